// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions.
// Byte width used across the receive path.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/byte_fifo_mem.sv
// Byte storage array for the receive FIFO.
// One write port, one asynchronous read port; contents are not reset.
module byte_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  uart_byte_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output uart_byte_t        rdata
);

  uart_byte_t mem [DEPTH];

  // Store the incoming byte when the FIFO accepts a push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// Edge-detects the stop-bit level, buffers bytes, streams them out.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_ready,
  output logic [UART_DATA_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic              rx_ready_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              push_req;
  logic              pop;
  logic              push;
  logic              drop;

  assign m_valid  = (cnt != '0);
  assign full     = (cnt == FULL_CNT);
  assign count    = cnt;
  assign push_req = rx_ready & ~rx_ready_q;
  assign pop      = m_valid & m_ready;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Track the stop-bit level; reset high so a level held across reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_q <= 1'b1;
    end else begin
      rx_ready_q <= rx_ready;
    end
  end

  // Advance pointers and occupancy on accepted pushes and pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  byte_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DEPTH = 4.
// Expected bytes are queued at stimulus time and compared on handshake.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_ready = 1'b0;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              overflow_clr = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample at negedge, compare any handshake, then move past posedge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      n_pops++;
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b, input bit acc);
    rx_data  = b;
    rx_ready = 1'b1;
    if (acc) exp_q.push_back(b);
    repeat (3) tick();
    rx_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    m_ready = 1'b0;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    int p0;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) tick();

    // Single byte with a long stop bit
    m_ready  = 1'b1;
    p0       = n_pops;
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    repeat (20) tick();
    rx_ready = 1'b0;
    repeat (2) tick();
    chk("single_pops", 32'(n_pops - p0), 32'd1);
    chk("single_count", 32'(count), 32'd0);
    chk("single_ovf", 32'(overflow), 32'd0);
    m_ready = 1'b0;

    // Fill and overflow
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ovf_pre", 32'(overflow), 32'd0);
    frame(8'h05, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Push/pop collision at full
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b1);
    chk("col_full", 32'(full), 32'd1);
    rx_data  = 8'h14;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    exp_q.push_back(8'h14);
    tick();
    m_ready = 1'b0;
    chk("col_count", 32'(count), 32'd4);
    chk("col_ovf", 32'(overflow), 32'd0);
    repeat (3) tick();
    rx_ready = 1'b0;
    tick();
    chk("col_hold", 32'(count), 32'd4);
    drain();

    // Pointer wrap with random stalls, never overflowing
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      m_ready  = (exp_q.size() >= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      rx_data  = 8'h40 + 8'(i);
      rx_ready = 1'b1;
      exp_q.push_back(8'h40 + 8'(i));
      tick();
      m_ready = 1'($urandom_range(0, 1));
      tick();
      rx_ready = 1'b0;
      m_ready  = 1'($urandom_range(0, 1));
      tick();
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Reset mid-stream with rx_ready held high
    for (int i = 0; i < 3; i++) frame(8'h60 + 8'(i), 1'b1);
    chk("mid_count_pre", 32'(count), 32'd3);
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(m_valid), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    repeat (5) tick();
    chk("mid_nopush", 32'(count), 32'd0);
    rx_ready = 1'b0;
    tick();
    m_ready = 1'b1;
    p0      = n_pops;
    frame(8'h99, 1'b1);
    chk("mid_next_pop", 32'(n_pops - p0), 32'd1);
    m_ready = 1'b0;

    // Overflow set and clear in the same cycle
    for (int i = 0; i < 4; i++) frame(8'h80 + 8'(i), 1'b1);
    rx_data      = 8'hEE;
    rx_ready     = 1'b1;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("setclr_ovf", 32'(overflow), 32'd1);
    chk("setclr_count", 32'(count), 32'd4);
    repeat (2) tick();
    rx_ready = 1'b0;
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
